led_refresh_scheduler: RTL and testbench

Consumer end of the activity-request line: receives the single-cycle activity pulses produced from the six player inputs (plus the boot pulse) and turns them into LED-strip frame transmissions. It handshakes with the strip transmitter, coalesces requests that arrive mid-frame into one pending refresh, and enforces the strip latch gap between frames. It also watches for a transmitter that never completes.

---
 rtl/led_refresh_scheduler.sv | 134 +++++++++++++
 tb/tb_led_refresh_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_refresh_scheduler.sv
// led_refresh_scheduler
//   Turns single-cycle activity requests into LED-strip frame transmissions.
//   Requests that arrive while a frame is in flight collapse into one pending
//   refresh. Each frame is followed by a latch gap of LATCH_CYCLES idle cycles,
//   and a watchdog aborts a frame the transmitter never finishes.
//
// Parameters
//   LATCH_CYCLES     minimum idle cycles after each frame (>= 1)
//   WATCHDOG_CYCLES  maximum cycles spent in SEND before abort (>= 2)
//
// Ports
//   clk             system clock, posedge
//   reset           synchronous, active-high reset
//   activity        refresh request, one request per cycle sampled high
//   frame_ready     transmitter can accept a start
//   frame_done      one-cycle pulse, transmitter finished the frame
//   frame_start     start strobe to the transmitter
//   pending         a refresh is queued behind the current frame
//   coalesce_count  saturating count of requests merged into a pending refresh
//   timeout         sticky, a frame was aborted by the watchdog
module led_refresh_scheduler #(
  parameter int unsigned LATCH_CYCLES    = 2500,
  parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic       frame_ready,
  input  logic       frame_done,
  output logic       frame_start,
  output logic       pending,
  output logic [7:0] coalesce_count,
  output logic       timeout
);

  localparam int unsigned WdW  = $clog2(WATCHDOG_CYCLES);
  localparam int unsigned LatW = $clog2(LATCH_CYCLES + 1);

  localparam logic [WdW-1:0]  WdLast  = WdW'(WATCHDOG_CYCLES - 1);
  localparam logic [LatW-1:0] LatLoad = LatW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSend,
    StLatch
  } state_e;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic [7:0]      coalesce_q, coalesce_d;
  logic            timeout_q, timeout_d;
  logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
  logic [LatW-1:0] latch_cnt_q, latch_cnt_d;

  logic busy;
  logic pending_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      coalesce_q  <= 8'd0;
      timeout_q   <= 1'b0;
      wd_cnt_q    <= '0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      coalesce_q  <= coalesce_d;
      timeout_q   <= timeout_d;
      wd_cnt_q    <= wd_cnt_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    wd_cnt_d    = '0;
    latch_cnt_d = latch_cnt_q;

    busy         = (state_q != StIdle);
    pending_next = pending_q | (activity & busy);
    pending_d    = pending_next;

    // Only requests landing on an already-queued refresh are counted as merged.
    coalesce_d = coalesce_q;
    if (activity && busy && pending_q && (coalesce_q != 8'hFF)) begin
      coalesce_d = coalesce_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (activity) state_d = StStart;
      end
      StStart: begin
        if (frame_ready) state_d = StSend;
      end
      StSend: begin
        wd_cnt_d = wd_cnt_q + WdW'(1);
        // A completion in the final watchdog cycle still wins over the abort.
        if (frame_done) begin
          state_d     = StLatch;
          latch_cnt_d = LatLoad;
        end else if (wd_cnt_q == WdLast) begin
          state_d     = StLatch;
          latch_cnt_d = LatLoad;
          timeout_d   = 1'b1;
        end
      end
      StLatch: begin
        if (latch_cnt_q == '0) begin
          // pending_next includes a request in this very cycle.
          if (pending_next) begin
            state_d   = StStart;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          latch_cnt_d = latch_cnt_q - LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign frame_start    = (state_q == StStart) & frame_ready;
  assign pending        = pending_q;
  assign coalesce_count = coalesce_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Bench for led_refresh_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a phase/age reference model.
module tb_led_refresh_scheduler;

  localparam int unsigned LatchCycles = 4;
  localparam int unsigned WdCycles    = 16;

  localparam int PIdle  = 0;
  localparam int PStart = 1;
  localparam int PSend  = 2;
  localparam int PLatch = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       activity;
  logic       frame_ready;
  logic       frame_done;
  logic       frame_start;
  logic       pending;
  logic [7:0] coalesce_count;
  logic       timeout;

  always #5 clk = ~clk;

  led_refresh_scheduler #(
    .LATCH_CYCLES    (LatchCycles),
    .WATCHDOG_CYCLES (WdCycles)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .activity       (activity),
    .frame_ready    (frame_ready),
    .frame_done     (frame_done),
    .frame_start    (frame_start),
    .pending        (pending),
    .coalesce_count (coalesce_count),
    .timeout        (timeout)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int fs_cnt = 0;
  bit last_fs;

  // Reference model: phase plus how long it has lasted / how long remains.
  int m_phase;
  int m_send_age;    // SEND cycles elapsed including the current one
  int m_latch_left;  // LATCH cycles remaining including the current one
  bit m_pending;
  bit m_timeout;
  int m_coal;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase      = PIdle;
    m_send_age   = 0;
    m_latch_left = 0;
    m_pending    = 1'b0;
    m_timeout    = 1'b0;
    m_coal       = 0;
  endtask

  task automatic model_step(input bit rs, input bit a, input bit r, input bit d);
    bit busy;
    bit pend_n;
    if (rs) begin
      model_reset();
      return;
    end
    busy   = (m_phase != PIdle);
    pend_n = m_pending || (a && busy);
    if (a && busy && m_pending && m_coal < 255) m_coal++;
    case (m_phase)
      PIdle:  if (a) m_phase = PStart;
      PStart: if (r) begin
        m_phase    = PSend;
        m_send_age = 1;
      end
      PSend: begin
        if (d || m_send_age == WdCycles) begin
          if (!d) m_timeout = 1'b1;
          m_phase      = PLatch;
          m_latch_left = LatchCycles;
        end else begin
          m_send_age++;
        end
      end
      default: begin
        if (m_latch_left == 1) begin
          if (pend_n) begin
            m_phase = PStart;
            pend_n  = 1'b0;
          end else begin
            m_phase = PIdle;
          end
        end else begin
          m_latch_left--;
        end
      end
    endcase
    m_pending = pend_n;
  endtask

  // Called at a negedge: drive, check outputs, advance model on the posedge.
  task automatic cycle(input bit rs, input bit a, input bit r, input bit d);
    reset       = rs;
    activity    = a;
    frame_ready = r;
    frame_done  = d;
    #1;
    check_val("frame_start", frame_start, (m_phase == PStart) && r);
    check_val("pending", pending, m_pending);
    check_val("coalesce_count", coalesce_count, m_coal);
    check_val("timeout", timeout, m_timeout);
    last_fs = frame_start;
    if (frame_start === 1'b1) fs_cnt++;
    @(posedge clk);
    model_step(rs, a, r, d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit a, input bit r, input bit d);
    repeat (n) cycle(1'b0, a, r, d);
  endtask

  initial begin
    int fs0;
    reset       = 1'b1;
    activity    = 1'b1;
    frame_ready = 1'b0;
    frame_done  = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with activity high, then released quietly.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run(5, 0, 1, 0);
    check_val("reset_no_start", fs_cnt, 0);

    // Single request, frame_done 5 cycles after frame_start.
    fs0 = fs_cnt;
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    check_val("single_start", last_fs, 1);
    run(4, 0, 1, 0);
    run(1, 0, 1, 1);
    run(6, 0, 1, 0);
    check_val("single_count", fs_cnt - fs0, 1);

    // Coalescing: three pulses during SEND.
    fs0 = fs_cnt;
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    check_val("coal_pending", pending, 1);
    run(1, 1, 1, 0);
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    check_val("coal_count2", coalesce_count, 2);
    run(1, 0, 1, 1);
    run(4, 0, 1, 0);
    run(1, 0, 1, 0);
    check_val("coal_restart", last_fs, 1);
    check_val("coal_pend_clr", pending, 0);
    run(2, 0, 1, 0);
    run(1, 0, 1, 1);
    run(6, 0, 1, 0);
    check_val("coal_frames", fs_cnt - fs0, 2);

    // Ready stall for 7 cycles.
    fs0 = fs_cnt;
    run(1, 1, 0, 0);
    run(7, 0, 0, 0);
    check_val("stall_no_start", fs_cnt - fs0, 0);
    run(1, 0, 1, 0);
    check_val("stall_start", last_fs, 1);
    run(1, 0, 0, 1);
    run(6, 0, 0, 0);

    // Watchdog: frame_done never arrives.
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    run(WdCycles - 1, 0, 1, 0);
    check_val("wd_not_yet", timeout, 0);
    run(1, 0, 1, 0);
    check_val("wd_timeout", timeout, 1);
    run(LatchCycles + 2, 0, 1, 0);
    run(1, 1, 1, 0);
    run(2, 0, 1, 0);
    run(1, 0, 1, 1);
    run(6, 0, 1, 0);
    check_val("wd_sticky", timeout, 1);

    // Request in the final LATCH cycle goes straight to START.
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    run(1, 0, 1, 1);
    run(LatchCycles - 1, 0, 1, 0);
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    check_val("latch_final_start", last_fs, 1);
    run(1, 0, 1, 1);
    run(6, 0, 1, 0);

    // Reset while in SEND.
    run(1, 1, 1, 0);
    run(1, 0, 1, 0);
    run(1, 1, 1, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    fs0 = fs_cnt;
    run(8, 0, 1, 0);
    check_val("reset_send_idle", fs_cnt - fs0, 0);

    // Activity held high long enough to saturate the coalesce counter.
    repeat (600) cycle(1'b0, 1'b1, 1'b1, $urandom_range(0, 3) == 0);
    check_val("coal_sat", coalesce_count, 255);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    repeat (3000) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
